mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have no parameters; all datapaths SHALL be fixed at 32 bits, with a 64-bit internal product.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend.
REQ-007 b  input  32  multiplier or divisor.
REQ-008 mthi  input  1  write wdata to HI.
REQ-009 mtlo  input  1  write wdata to LO.
REQ-010 wdata  input  32  data for mthi/mtlo.
REQ-011 cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-012 busy  output  1  operation in progress; the pipeline SHALL stall on it.
REQ-013 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-014 hi  output  32  HI register, driven directly from a flop.
REQ-015 lo  output  32  LO register, driven directly from a flop.

Function
REQ-016 State machine: IDLE, RUN, FIN.
  - IDLE->RUN on start.
  - RUN->FIN after exactly 32 RUN cycles (5-bit counter, 0..31).
  - FIN->IDLE unconditionally.
REQ-017 On the start edge E0, the block SHALL latch op, the operand magnitudes and the result signs.
  - Magnitude = two's-complement absolute value for signed ops; the raw value for unsigned ops.
REQ-018 Timing from E0:
  - busy SHALL be 1 for exactly 33 cycles (32 RUN + FIN).
  - hi/lo SHALL load at edge E33.
  - busy SHALL be 0 and done SHALL be 1 in the single cycle after E33.
REQ-019 Multiply: radix-2 shift-add, one bit per RUN cycle; {hi,lo} SHALL receive the 64-bit product.
  - MULT: the product SHALL be negated in FIN when the operand signs differ.
REQ-020 Divide: restoring, one quotient bit per RUN cycle; lo SHALL receive the quotient, hi the remainder.
  - DIV: the quotient SHALL be negated when the operand signs differ.
  - DIV: the remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero (DIV or DIVU, b=0):
  - same 33-cycle latency;
  - lo=32'hFFFFFFFF, hi=a unmodified;
  - no sign correction.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0, with no error indication.
REQ-023 start while in RUN or FIN SHALL be ignored.
REQ-024 mthi/mtlo in IDLE SHALL write the register at the next edge.
  - mthi/mtlo in RUN or FIN SHALL be ignored.
  - mthi and mtlo together SHALL write both registers.
REQ-025 start and mthi/mtlo asserted together in IDLE: start SHALL win and the moves SHALL be ignored.
REQ-026 cancel in RUN or FIN SHALL return the block to IDLE at the next edge.
  - hi/lo SHALL be unchanged and no done SHALL be produced.
  - cancel and start together in IDLE: start SHALL be ignored.
  - cancel in FIN SHALL take priority over the HI/LO write.
REQ-027 done SHALL never be asserted for two consecutive cycles.
  - A new start SHALL be accepted in the done cycle, because the block is already back in IDLE.

Reset
REQ-028 While reset_n=0 at a clock edge:
  - state SHALL be IDLE;
  - hi=0, lo=0, busy=0, done=0;
  - the counter and operand registers SHALL clear.
REQ-029 Reset mid-operation SHALL abort the operation with no done and hi/lo=0.
  - Reset SHALL take priority over start, cancel, mthi and mtlo.
REQ-030 Asynchronous assertion of reset_n SHALL have no effect until the next rising clk edge.

Verification
REQ-031 MULT a=32'hFFFFFFFD (-3), b=7 -> busy 33 cycles, then done pulse; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-032 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-033 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - Then DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-034 DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064 after 33 cycles.
REQ-035 mtlo wdata=32'h12345678 in IDLE, then MULTU 5x6 with cancel at RUN cycle 10 -> busy drops next cycle, no done, lo=32'h12345678; a new start is accepted immediately.
REQ-036 start, then reset_n=0 at RUN cycle 20 -> next edge hi=lo=0, busy=0; mthi asserted during RUN is ignored; start+mthi together in IDLE -> only the operation runs.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// 33-cycle latency (32 RUN cycles + FIN), cancel and move-to-HI/LO support.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [63:0] acc;       // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;      // multiplicand (mult) or divisor (div) magnitude
  logic        is_div;
  logic        neg_res;   // product / quotient must be negated
  logic        neg_rem;   // dividend was negative (signed ops only)
  logic        div_zero;

  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        start_ok;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes, one iteration step and the final sign correction
  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && a[31]) ? -a : a;
    b_mag     = (is_signed && b[31]) ? -b : b;
    start_ok  = (state == IDLE) && start && !cancel;

    sum    = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    rem_sh = acc[63:31];
    fits   = rem_sh >= {1'b0, opnd};
    // When the trial subtraction fits, the true difference is below opnd,
    // so the low 32 bits are exact.
    diff   = rem_sh[31:0] - opnd;
    if (is_div)
      step = fits ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      step = {sum, acc[31:1]};

    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[31:0] : acc[31:0];
    // With a zero divisor the remainder register ends holding |a|, so
    // restoring the dividend sign reproduces a unmodified.
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and busy decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cancel)              state_nxt = IDLE;
        else if (count == 5'd31) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            count    <= '0;
            is_div   <= op[1];
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {32'd0, (op[1] ? a_mag : b_mag)};
            neg_res  <= is_signed && (a[31] ^ b[31]);
            neg_rem  <= is_signed && a[31];
            div_zero <= op[1] && (b == 32'd0);
          end else if (!start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (!cancel) begin
            acc   <= step;
            count <= count + 5'd1;
          end
        end
        FIN: begin
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= div_zero ? '1 : quot_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n, start, mthi, mtlo, cancel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start request and take the E0 edge.
  task automatic begin_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Count busy cycles (bounded), optionally injecting ignored start/moves, then check result.
  task automatic finish_op(input string tag, input bit inject,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 1;
    chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
    while (busy === 1'b1 && n < 40) begin
      if (inject && n >= 5 && n < 8) begin
        start = 1'b1; op = 2'b11; a = 32'h0000_0009; b = 32'h0000_0003;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      tick();
      if (busy === 1'b1) n++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, "_busy_cycles"}, n, 33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic idle_tick(input string tag);
    tick();
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(); tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // MULT -3 * 7 = -21
    begin_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult_neg", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    idle_tick("mult_neg");

    // MULTU max*max, then DIV issued in the done cycle with ignored start/moves mid-run
    begin_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    begin_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    idle_tick("div_neg");

    begin_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 1'b0, 32'h0000_0000, 32'h8000_0000);
    idle_tick("div_ovf");

    begin_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_negb", 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    idle_tick("div_negb");

    begin_op(2'b11, 32'd100, 32'd0);
    finish_op("divu_zero", 1'b0, 32'h0000_0064, 32'hFFFF_FFFF);
    idle_tick("divu_zero");

    begin_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    finish_op("div_zero", 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    idle_tick("div_zero");

    begin_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_min", 1'b0, 32'h4000_0000, 32'h0000_0000);
    idle_tick("mult_min");

    // mthi + mtlo together
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'hCAFE_F00D);
    chk("mtboth_lo", lo, 32'hCAFE_F00D);

    // mtlo, then cancel at RUN cycle 10
    mtlo = 1'b1; wdata = 32'h1234_5678;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi", hi, 32'hCAFE_F00D);
    begin_op(2'b01, 32'd5, 32'd6);
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_run_busy", {31'd0, busy}, 32'd0);
    chk("cancel_run_done", {31'd0, done}, 32'd0);
    chk("cancel_run_lo", lo, 32'h1234_5678);
    chk("cancel_run_hi", hi, 32'hCAFE_F00D);
    begin_op(2'b01, 32'd5, 32'd6);
    finish_op("restart", 1'b0, 32'd0, 32'd30);
    idle_tick("restart");

    // cancel in FIN beats the HI/LO write
    begin_op(2'b01, 32'd2, 32'd3);
    repeat (32) tick();
    chk("fin_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_fin_busy", {31'd0, busy}, 32'd0);
    chk("cancel_fin_done", {31'd0, done}, 32'd0);
    chk("cancel_fin_lo", lo, 32'd30);
    idle_tick("cancel_fin");

    // cancel + start in IDLE: start ignored
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);

    // reset at RUN cycle 20, with start/mthi also asserted
    begin_op(2'b00, 32'd3, 32'd5);
    repeat (19) tick();
    reset_n = 1'b0; start = 1'b1; mthi = 1'b1; wdata = 32'h7777_7777;
    tick();
    chk("rst_run_hi", hi, 32'd0);
    chk("rst_run_lo", lo, 32'd0);
    chk("rst_run_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1; start = 1'b0; mthi = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // start + mthi in IDLE: only the operation runs
    mthi = 1'b1; wdata = 32'h0000_0055;
    tick();
    chk("mthi_hi", hi, 32'h0000_0055);
    wdata = 32'h0000_00AA;
    begin_op(2'b01, 32'd7, 32'd9);
    chk("start_mthi_hi", hi, 32'h0000_0055);
    chk("start_mthi_busy", {31'd0, busy}, 32'd1);
    finish_op("start_mthi", 1'b0, 32'd0, 32'd63);
    idle_tick("start_mthi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
